// File: rtl/inst_rom_loader_pkg.sv
// Shared constants for the instruction ROM loader: bus widths, the NOP word,
// enable polarities and the 2-bit loader state encoding.
package inst_rom_loader_pkg;

  localparam int          INST_BUS_W  = 32;      // instruction word width
  localparam int          INST_ADDR_W = 32;      // fetch byte-address width
  localparam logic [31:0] ZERO_WORD   = 32'h0;   // returned when no valid fetch
  localparam logic        CHIP_ENABLE = 1'b1;    // ce_i level that enables a fetch
  localparam logic        RST_ENABLE  = 1'b1;    // rst level that resets the block

  // Loader states, explicit 2-bit encodings.
  typedef enum logic [1:0] {
    S_LOAD    = 2'b00,
    S_RELEASE = 2'b01,
    S_RUN     = 2'b10
  } state_e;

  // State entered out of reset, selected by the BOOT_LOAD parameter.
  function automatic state_e reset_state(input bit boot_load);
    return boot_load ? S_LOAD : S_RUN;
  endfunction

endpackage

// File: rtl/inst_ram.sv
// DEPTH x 32 instruction store: one synchronous write port for the boot
// loader and one asynchronous read port for the zero-latency fetch path.
module inst_ram
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [INST_BUS_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [INST_BUS_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [INST_BUS_W-1:0] r_mem [DEPTH];

  // Write one word per accepted load beat.
  // NOTE: the array has no reset on purpose; contents must survive rst so an
  // aborted load keeps already-written words, and a reset would stop the
  // array mapping onto RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Combinational read so the core sees its instruction in the same cycle.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction-memory responder for the core fetch port with a streaming
// boot-load port. Holds the core in reset while an image is loading and for
// RELEASE_CYC cycles after the last beat.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter bit BOOT_LOAD   = 1'b1,
  parameter int RELEASE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic [INST_ADDR_W-1:0] addr_i,
  output logic [INST_BUS_W-1:0]  inst_o,
  input  logic                   load_start_i,
  input  logic                   load_valid_i,
  input  logic [INST_BUS_W-1:0]  load_data_i,
  input  logic                   load_last_i,
  output logic                   load_ready_o,
  output logic                   cpu_rst_o,
  output logic [ADDR_W:0]        load_count_o,
  output logic                   overflow_o
);

  localparam int                REL_W    = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
  localparam logic [REL_W-1:0]  REL_LAST = REL_W'(RELEASE_CYC - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_W:0]       r_wptr;       // words written; saturates at DEPTH
  logic                  r_overflow;
  logic [REL_W-1:0]      r_rel_cnt;

  logic                  w_load_ready;
  logic                  w_cpu_rst;
  logic                  w_accept;
  logic                  w_ptr_full;
  logic                  w_we;
  logic                  w_start_load;
  logic                  w_addr_in_range;
  logic                  w_fetch_en;
  logic [ADDR_W-1:0]     w_raddr;
  logic [INST_BUS_W-1:0] w_rdata;
  logic                  w_unused_addr_lsb;

  // State register; reset lands in the BOOT_LOAD-selected state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state <= reset_state(BOOT_LOAD);
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake/core-reset decode.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_ready = 1'b0;
    w_cpu_rst    = 1'b1;
    if (rst != RST_ENABLE) begin
      case (r_state)
        S_LOAD: begin
          w_load_ready = 1'b1;
          if (load_valid_i && load_last_i) begin
            w_state_nxt = S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (r_rel_cnt == REL_LAST) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          w_cpu_rst = 1'b0;
          if (load_start_i) begin
            w_state_nxt = S_LOAD;
          end
        end
        default: begin
          w_state_nxt = reset_state(BOOT_LOAD);
        end
      endcase
    end
  end

  assign w_accept     = w_load_ready & load_valid_i;
  assign w_ptr_full   = r_wptr[ADDR_W];
  assign w_we         = w_accept & ~w_ptr_full;
  assign w_start_load = (r_state == S_RUN) & load_start_i;

  // Write pointer / load count and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_wptr     <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_load) begin
      r_wptr     <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      if (w_ptr_full) begin
        r_overflow <= 1'b1;
      end else begin
        r_wptr <= r_wptr + 1'b1;
      end
    end
  end

  // Release counter runs only in S_RELEASE and sits at zero otherwise, so it
  // always starts from zero on entry.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_rel_cnt <= '0;
    end else if (r_state == S_RELEASE) begin
      r_rel_cnt <= r_rel_cnt + 1'b1;
    end else begin
      r_rel_cnt <= '0;
    end
  end

  // Fetch decode: word index from the byte address, upper bits must be zero.
  assign w_raddr           = addr_i[ADDR_W+1:2];
  assign w_addr_in_range   = (addr_i[INST_ADDR_W-1:ADDR_W+2] == '0);
  assign w_unused_addr_lsb = ^addr_i[1:0];
  assign w_fetch_en        = (rst != RST_ENABLE) && (r_state == S_RUN) &&
                             (ce_i == CHIP_ENABLE) && w_addr_in_range;

  inst_ram #(
    .ADDR_W (ADDR_W)
  ) u_inst_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr[ADDR_W-1:0]),
    .i_wdata (load_data_i),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign inst_o       = w_fetch_en ? w_rdata : ZERO_WORD;
  assign load_ready_o = w_load_ready;
  assign cpu_rst_o    = w_cpu_rst;
  assign load_count_o = r_wptr;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a default instance, an ADDR_W=2
// instance for overflow, and a BOOT_LOAD=0 instance for direct run.
module tb_inst_rom_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Main instance (ADDR_W=10, BOOT_LOAD=1, RELEASE_CYC=2)
  logic        m_rst, m_ce, m_start, m_valid, m_last;
  logic [31:0] m_addr, m_data, m_inst;
  logic        m_ready, m_cpu_rst, m_ovf;
  logic [10:0] m_count;

  // Small instance (ADDR_W=2)
  logic        s_rst, s_ce, s_start, s_valid, s_last;
  logic [31:0] s_addr, s_data, s_inst;
  logic        s_ready, s_cpu_rst, s_ovf;
  logic [2:0]  s_count;

  // No-boot-load instance
  logic        n_rst, n_ce, n_start, n_valid, n_last;
  logic [31:0] n_addr, n_data, n_inst;
  logic        n_ready, n_cpu_rst, n_ovf;
  logic [10:0] n_count;

  inst_rom_loader #(.ADDR_W(10), .BOOT_LOAD(1'b1), .RELEASE_CYC(2)) u_main (
    .clk(clk), .rst(m_rst), .ce_i(m_ce), .addr_i(m_addr), .inst_o(m_inst),
    .load_start_i(m_start), .load_valid_i(m_valid), .load_data_i(m_data),
    .load_last_i(m_last), .load_ready_o(m_ready), .cpu_rst_o(m_cpu_rst),
    .load_count_o(m_count), .overflow_o(m_ovf)
  );

  inst_rom_loader #(.ADDR_W(2), .BOOT_LOAD(1'b1), .RELEASE_CYC(2)) u_small (
    .clk(clk), .rst(s_rst), .ce_i(s_ce), .addr_i(s_addr), .inst_o(s_inst),
    .load_start_i(s_start), .load_valid_i(s_valid), .load_data_i(s_data),
    .load_last_i(s_last), .load_ready_o(s_ready), .cpu_rst_o(s_cpu_rst),
    .load_count_o(s_count), .overflow_o(s_ovf)
  );

  inst_rom_loader #(.ADDR_W(10), .BOOT_LOAD(1'b0), .RELEASE_CYC(2)) u_noboot (
    .clk(clk), .rst(n_rst), .ce_i(n_ce), .addr_i(n_addr), .inst_o(n_inst),
    .load_start_i(n_start), .load_valid_i(n_valid), .load_data_i(n_data),
    .load_last_i(n_last), .load_ready_o(n_ready), .cpu_rst_o(n_cpu_rst),
    .load_count_o(n_count), .overflow_o(n_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_beat(input logic [31:0] d, input logic l);
    m_valid = 1'b1; m_data = d; m_last = l;
    tick();
    m_valid = 1'b0; m_last = 1'b0;
  endtask

  task automatic s_beat(input logic [31:0] d, input logic l);
    s_valid = 1'b1; s_data = d; s_last = l;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic m_fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
    m_ce = 1'b1; m_addr = a;
    #1;
    check(tag, m_inst, exp);
  endtask

  task automatic s_fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
    s_ce = 1'b1; s_addr = a;
    #1;
    check(tag, s_inst, exp);
  endtask

  logic [31:0] img [4] = '{32'h34010001, 32'h34020002, 32'h00221821, 32'h00000000};

  initial begin
    m_rst = 1'b1; m_ce = 1'b1; m_addr = '0; m_start = 1'b0; m_valid = 1'b0; m_data = '0; m_last = 1'b0;
    s_rst = 1'b1; s_ce = 1'b0; s_addr = '0; s_start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    n_rst = 1'b1; n_ce = 1'b1; n_addr = '0; n_start = 1'b0; n_valid = 1'b0; n_data = '0; n_last = 1'b0;

    // ---- Reset values ----
    tick();
    check("rst_cpu_rst", 32'(m_cpu_rst), 32'd1);
    check("rst_ready",   32'(m_ready),   32'd0);
    check("rst_inst",    m_inst,         32'h0);
    check("rst_count",   32'(m_count),   32'd0);
    check("rst_ovf",     32'(m_ovf),     32'd0);
    check("nb_rst_cpu_rst", 32'(n_cpu_rst), 32'd1);
    check("nb_rst_inst",    n_inst,         32'h0);
    m_rst = 1'b0; s_rst = 1'b0; n_rst = 1'b0;
    #1;
    check("nb_run_cpu_rst", 32'(n_cpu_rst), 32'd0);
    check("nb_run_ready",   32'(n_ready),   32'd0);
    check("boot_ready",     32'(m_ready),   32'd1);
    check("boot_cpu_rst",   32'(m_cpu_rst), 32'd1);

    // ---- Boot load of 4 beats ----
    for (int i = 0; i < 4; i++) begin
      check("load4_ready", 32'(m_ready), 32'd1);
      m_beat(img[i], i == 3);
    end
    check("load4_count",   32'(m_count),   32'd4);
    check("rel0_cpu_rst",  32'(m_cpu_rst), 32'd1);
    check("rel0_ready",    32'(m_ready),   32'd0);
    m_fetch("rel0_fetch_nop", 32'h8, 32'h0);
    tick();
    check("rel1_cpu_rst",  32'(m_cpu_rst), 32'd1);
    tick();
    check("run_cpu_rst",   32'(m_cpu_rst), 32'd0);
    m_fetch("fetch_0x8", 32'h8, 32'h00221821);

    // ---- Fetch decode in S_RUN ----
    m_ce = 1'b0; #1;
    check("fetch_ce0", m_inst, 32'h0);
    m_fetch("fetch_oor", 32'h00001000, 32'h0);
    m_fetch("fetch_0x5", 32'h5, 32'h34020002);

    // ---- Reload with valid gaps ----
    tick();
    m_addr = 32'h0; m_ce = 1'b1; m_start = 1'b1; #1;
    check("start_cycle_fetch", m_inst, 32'h34010001);
    tick();
    m_start = 1'b0;
    check("gap_cpu_rst", 32'(m_cpu_rst), 32'd1);
    check("gap_count0",  32'(m_count),   32'd0);
    m_beat(32'h11111111, 1'b0);
    // last without valid plus a start request: both must be ignored
    m_last = 1'b1; m_start = 1'b1;
    check("gap1_ready", 32'(m_ready), 32'd1);
    tick();
    m_last = 1'b0; m_start = 1'b0;
    check("gap_last_novalid_ready", 32'(m_ready), 32'd1);
    check("gap_last_novalid_count", 32'(m_count), 32'd1);
    m_beat(32'h22222222, 1'b0);
    check("gap2_ready", 32'(m_ready), 32'd1);
    tick();
    m_beat(32'h33333333, 1'b1);
    check("gap_count3", 32'(m_count), 32'd3);
    tick(); tick();
    check("gap_run", 32'(m_cpu_rst), 32'd0);
    m_fetch("gap_mem0", 32'h0, 32'h11111111);
    m_fetch("gap_mem1", 32'h4, 32'h22222222);
    m_fetch("gap_mem2", 32'h8, 32'h33333333);
    m_fetch("gap_mem3", 32'hC, 32'h00000000);

    // ---- Single-beat reload ----
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    check("re1_cpu_rst", 32'(m_cpu_rst), 32'd1);
    m_beat(32'hDEADBEEF, 1'b1);
    check("re1_count", 32'(m_count), 32'd1);
    check("re1_ovf",   32'(m_ovf),   32'd0);
    tick(); tick();
    m_fetch("re1_mem0", 32'h0, 32'hDEADBEEF);
    m_fetch("re1_mem1", 32'h4, 32'h22222222);

    // ---- rst mid-load ----
    m_start = 1'b1;
    tick();
    m_start = 1'b0;
    m_beat(32'h000000A0, 1'b0);
    m_beat(32'h000000A1, 1'b0);
    m_rst = 1'b1; m_valid = 1'b1; m_data = 32'h000000A2;
    tick();
    m_valid = 1'b0;
    check("abort_cpu_rst", 32'(m_cpu_rst), 32'd1);
    check("abort_count",   32'(m_count),   32'd0);
    m_rst = 1'b0; #1;
    check("abort_load_ready", 32'(m_ready), 32'd1);
    m_beat(32'hCAFEF00D, 1'b1);
    check("abort_fresh_count", 32'(m_count), 32'd1);
    tick(); tick();
    check("abort_run", 32'(m_cpu_rst), 32'd0);
    m_fetch("abort_mem0", 32'h0, 32'hCAFEF00D);
    m_fetch("abort_mem1", 32'h4, 32'h000000A1);
    m_fetch("abort_mem2", 32'h8, 32'h33333333);

    // ---- Overflow on the ADDR_W=2 instance ----
    for (int i = 0; i < 6; i++) begin
      s_beat(32'h10 + 32'(i), i == 5);
      if (i == 3) begin
        check("ovf_count_at4", 32'(s_count), 32'd4);
        check("ovf_flag_at4",  32'(s_ovf),   32'd0);
      end
      if (i == 4) begin
        check("ovf_flag_at5", 32'(s_ovf), 32'd1);
      end
    end
    check("ovf_count",   32'(s_count),   32'd4);
    check("ovf_flag",    32'(s_ovf),     32'd1);
    check("ovf_release", 32'(s_cpu_rst), 32'd1);
    check("ovf_ready",   32'(s_ready),   32'd0);
    tick(); tick();
    check("ovf_run", 32'(s_cpu_rst), 32'd0);
    for (int i = 0; i < 4; i++) begin
      s_fetch("ovf_mem", 32'(i * 4), 32'h10 + 32'(i));
      tick();
    end
    s_fetch("ovf_oor", 32'h10, 32'h0);

    // ---- Reload clears overflow ----
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check("s_re_cpu_rst", 32'(s_cpu_rst), 32'd1);
    check("s_re_ovf_clr", 32'(s_ovf),     32'd0);
    check("s_re_count0",  32'(s_count),   32'd0);
    s_beat(32'hDEADBEEF, 1'b1);
    check("s_re_count1", 32'(s_count), 32'd1);
    check("s_re_ovf",    32'(s_ovf),   32'd0);
    tick(); tick();
    s_fetch("s_re_mem0", 32'h0, 32'hDEADBEEF);
    s_fetch("s_re_mem1", 32'h4, 32'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
